// File: rtl/riscv_pkg.sv
// Shared types for the 5-stage core hazard logic.
package riscv_pkg;

    localparam int unsigned NREG_DEF = 32;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending bits and in-flight counter for variable-latency long ops.
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned NREG      = NREG_DEF,
    parameter int unsigned MAX_OUTST = 4,
    localparam int unsigned RW       = $clog2(NREG),
    localparam int unsigned OW       = $clog2(MAX_OUTST + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_i,
    input  logic            issue_wr_i,
    input  logic [RW-1:0]   issue_addr_i,
    input  logic            done_i,
    input  logic [RW-1:0]   done_addr_i,
    output logic [NREG-1:0] pending_o,
    output logic [OW-1:0]   outst_o,
    output logic            proto_err_o
);

    logic [NREG-1:0] r_pending;
    logic [OW-1:0]   r_outst;
    logic            r_proto_err;
    logic [NREG-1:0] w_pending_nxt;
    logic [OW-1:0]   w_outst_nxt;
    logic            w_done_ok;

    // A completion with nothing in flight is a protocol error and is ignored.
    assign w_done_ok = done_i && (r_outst != '0);

    // Clear first, then set, so a same-cycle reissue of the register stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_done_ok) begin
            w_pending_nxt[done_addr_i] = 1'b0;
        end
        if (issue_i && issue_wr_i && (issue_addr_i != '0)) begin
            w_pending_nxt[issue_addr_i] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_comb begin
        w_outst_nxt = r_outst;
        if (issue_i && !w_done_ok && (r_outst != OW'(MAX_OUTST))) begin
            w_outst_nxt = r_outst + OW'(1);
        end else if (!issue_i && w_done_ok) begin
            w_outst_nxt = r_outst - OW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending   <= '0;
            r_outst     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_outst   <= w_outst_nxt;
            if (done_i && (r_outst == '0)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign pending_o   = r_pending;
    assign outst_o     = r_outst;
    assign proto_err_o = r_proto_err;

endmodule

// File: rtl/hazard_unit_sb.sv
// Hazard controller: E-stage forwarding, load-use / scoreboard / capacity stalls, branch flush.
module hazard_unit_sb
    import riscv_pkg::*;
#(
    parameter int unsigned NREG      = NREG_DEF,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned RW       = $clog2(NREG),
    localparam int unsigned OW       = $clog2(MAX_OUTST + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [RW-1:0]   rs1D_addr_i,
    input  logic            rs1D_used_i,
    input  logic [RW-1:0]   rs2D_addr_i,
    input  logic            rs2D_used_i,
    input  logic [RW-1:0]   rdD_addr_i,
    input  logic            rdD_wr_ena_i,
    input  logic            longD_i,
    input  logic [RW-1:0]   rs1E_addr_i,
    input  logic [RW-1:0]   rs2E_addr_i,
    input  logic [RW-1:0]   rdE_addr_i,
    input  logic            rdE_wr_ena_i,
    input  logic            loadE_i,
    input  logic            longE_i,
    input  logic [RW-1:0]   rdM_addr_i,
    input  logic            rdM_wr_ena_i,
    input  logic [RW-1:0]   rdW_addr_i,
    input  logic            rdW_wr_ena_i,
    input  logic            lu_done_i,
    input  logic [RW-1:0]   lu_rd_i,
    input  logic            branch_taken_i,
    output fwd_sel_e        forwardAE_o,
    output fwd_sel_e        forwardBE_o,
    output logic            stallF_o,
    output logic            stallD_o,
    output logic            flushD_o,
    output logic            flushE_o,
    output logic [NREG-1:0] pending_o,
    output logic [OW-1:0]   outst_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic            proto_err_o
);

    logic [NREG-1:0]  w_pending;
    logic [NREG-1:0]  w_done_mask;
    logic [NREG-1:0]  w_pend_eff;
    logic [OW-1:0]    w_outst;
    logic             w_lu_stall;
    logic             w_sb_stall;
    logic             w_full_stall;
    logic             w_stall;
    logic [CNT_W-1:0] r_stall_cnt;

    function automatic fwd_sel_e fwd_sel(
        input logic [RW-1:0] rs,
        input logic [RW-1:0] rd_m,
        input logic          wr_m,
        input logic [RW-1:0] rd_w,
        input logic          wr_w
    );
        if (wr_m && (rs == rd_m) && (rs != '0)) begin
            return FWD_M;
        end else if (wr_w && (rs == rd_w) && (rs != '0)) begin
            return FWD_W;
        end
        return FWD_NONE;
    endfunction

    assign forwardAE_o = fwd_sel(rs1E_addr_i, rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i);
    assign forwardBE_o = fwd_sel(rs2E_addr_i, rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i);

    hazard_scoreboard #(
        .NREG      (NREG),
        .MAX_OUTST (MAX_OUTST)
    ) u_sb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .issue_i      (longE_i),
        .issue_wr_i   (rdE_wr_ena_i),
        .issue_addr_i (rdE_addr_i),
        .done_i       (lu_done_i),
        .done_addr_i  (lu_rd_i),
        .pending_o    (w_pending),
        .outst_o      (w_outst),
        .proto_err_o  (proto_err_o)
    );

    // Register file is write-first, so a completing register is already readable this cycle.
    assign w_done_mask = lu_done_i ? (NREG'(1) << lu_rd_i) : '0;
    assign w_pend_eff  = w_pending & ~w_done_mask;

    assign w_lu_stall = loadE_i && rdE_wr_ena_i && (rdE_addr_i != '0) &&
                        ((rs1D_used_i && (rs1D_addr_i == rdE_addr_i)) ||
                         (rs2D_used_i && (rs2D_addr_i == rdE_addr_i)));

    assign w_sb_stall = (rs1D_used_i  && w_pend_eff[rs1D_addr_i]) ||
                        (rs2D_used_i  && w_pend_eff[rs2D_addr_i]) ||
                        (rdD_wr_ena_i && w_pend_eff[rdD_addr_i]);

    assign w_full_stall = longD_i && (w_outst == OW'(MAX_OUTST)) && !lu_done_i;

    assign w_stall  = w_lu_stall || w_sb_stall || w_full_stall;
    assign stallF_o = w_stall && !branch_taken_i;
    assign stallD_o = w_stall && !branch_taken_i;
    assign flushD_o = branch_taken_i;
    assign flushE_o = w_stall || branch_taken_i;

    // Saturating count of D-stage stall cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (stallD_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign pending_o   = w_pending;
    assign outst_o     = w_outst;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed self-checking bench for hazard_unit_sb.
module tb_hazard_unit_sb;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  rs1D_addr_i, rs2D_addr_i, rdD_addr_i;
    logic        rs1D_used_i, rs2D_used_i, rdD_wr_ena_i, longD_i;
    logic [4:0]  rs1E_addr_i, rs2E_addr_i, rdE_addr_i;
    logic        rdE_wr_ena_i, loadE_i, longE_i;
    logic [4:0]  rdM_addr_i, rdW_addr_i, lu_rd_i;
    logic        rdM_wr_ena_i, rdW_wr_ena_i, lu_done_i, branch_taken_i;
    fwd_sel_e    forwardAE_o, forwardBE_o;
    logic        stallF_o, stallD_o, flushD_o, flushE_o;
    logic [31:0] pending_o;
    logic [2:0]  outst_o;
    logic [15:0] stall_cnt_o;
    logic        proto_err_o;

    int checks = 0;
    int failures = 0;

    hazard_unit_sb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs1D_addr_i(rs1D_addr_i), .rs1D_used_i(rs1D_used_i),
        .rs2D_addr_i(rs2D_addr_i), .rs2D_used_i(rs2D_used_i),
        .rdD_addr_i(rdD_addr_i), .rdD_wr_ena_i(rdD_wr_ena_i), .longD_i(longD_i),
        .rs1E_addr_i(rs1E_addr_i), .rs2E_addr_i(rs2E_addr_i),
        .rdE_addr_i(rdE_addr_i), .rdE_wr_ena_i(rdE_wr_ena_i),
        .loadE_i(loadE_i), .longE_i(longE_i),
        .rdM_addr_i(rdM_addr_i), .rdM_wr_ena_i(rdM_wr_ena_i),
        .rdW_addr_i(rdW_addr_i), .rdW_wr_ena_i(rdW_wr_ena_i),
        .lu_done_i(lu_done_i), .lu_rd_i(lu_rd_i), .branch_taken_i(branch_taken_i),
        .forwardAE_o(forwardAE_o), .forwardBE_o(forwardBE_o),
        .stallF_o(stallF_o), .stallD_o(stallD_o),
        .flushD_o(flushD_o), .flushE_o(flushE_o),
        .pending_o(pending_o), .outst_o(outst_o),
        .stall_cnt_o(stall_cnt_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1D_addr_i = '0; rs2D_addr_i = '0; rdD_addr_i = '0;
        rs1D_used_i = 0; rs2D_used_i = 0; rdD_wr_ena_i = 0; longD_i = 0;
        rs1E_addr_i = '0; rs2E_addr_i = '0; rdE_addr_i = '0;
        rdE_wr_ena_i = 0; loadE_i = 0; longE_i = 0;
        rdM_addr_i = '0; rdW_addr_i = '0; lu_rd_i = '0;
        rdM_wr_ena_i = 0; rdW_wr_ena_i = 0; lu_done_i = 0; branch_taken_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        clear_inputs();
        longE_i = 1; rdE_wr_ena_i = 1; rdE_addr_i = rd;
        tick();
    endtask

    task automatic complete(input logic [4:0] rd);
        clear_inputs();
        lu_done_i = 1; lu_rd_i = rd;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        #1;

        // Reset state with all-zero inputs
        chk("rst_pending", pending_o, 32'h0);
        chk("rst_outst", 32'(outst_o), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_proto_err", 32'(proto_err_o), 32'd0);
        chk("rst_fwdA", 32'(forwardAE_o), 32'(FWD_NONE));
        chk("rst_ctrl", {28'd0, stallF_o, stallD_o, flushD_o, flushE_o}, 32'h0);

        // 1: forwarding from M and W, M priority, x0 never forwarded
        rdM_addr_i = 5; rdM_wr_ena_i = 1; rdW_addr_i = 6; rdW_wr_ena_i = 1;
        rs1E_addr_i = 5; rs2E_addr_i = 6; #1;
        chk("fwd_A_M", 32'(forwardAE_o), 32'(FWD_M));
        chk("fwd_B_W", 32'(forwardBE_o), 32'(FWD_W));
        rdW_addr_i = 5; #1;
        chk("fwd_M_prio", 32'(forwardAE_o), 32'(FWD_M));
        rdM_addr_i = 0; rdW_addr_i = 0; rs1E_addr_i = 0; rs2E_addr_i = 0; #1;
        chk("fwd_x0_A", 32'(forwardAE_o), 32'(FWD_NONE));
        chk("fwd_x0_B", 32'(forwardBE_o), 32'(FWD_NONE));
        rdM_addr_i = 7; rdM_wr_ena_i = 0; rdW_addr_i = 7; rdW_wr_ena_i = 0; rs1E_addr_i = 7; #1;
        chk("fwd_no_wr", 32'(forwardAE_o), 32'(FWD_NONE));

        // 2: load-use stall, then branch overriding it
        clear_inputs();
        loadE_i = 1; rdE_wr_ena_i = 1; rdE_addr_i = 3; rs1D_addr_i = 3; rs1D_used_i = 1; #1;
        chk("lu_ctrl", {28'd0, stallF_o, stallD_o, flushD_o, flushE_o}, 32'b1101);
        tick();
        chk("lu_cnt", 32'(stall_cnt_o), 32'd1);
        branch_taken_i = 1; #1;
        chk("lu_branch_ctrl", {28'd0, stallF_o, stallD_o, flushD_o, flushE_o}, 32'b0011);
        tick();
        chk("lu_branch_cnt", 32'(stall_cnt_o), 32'd1);
        clear_inputs();
        loadE_i = 1; rdE_wr_ena_i = 1; rdE_addr_i = 0; rs1D_addr_i = 0; rs1D_used_i = 1; #1;
        chk("lu_x0", 32'(stallD_o), 32'd0);

        // 3: DIV x7 in flight, dependent ADD stalled 10 cycles, released on done
        do_reset();
        issue_long(7);
        chk("div_pending", pending_o, 32'h0000_0080);
        chk("div_outst", 32'(outst_o), 32'd1);
        clear_inputs();
        rs1D_addr_i = 7; rs1D_used_i = 1; #1;
        for (int i = 0; i < 10; i++) begin
            chk("div_stall", 32'(stallD_o), 32'd1);
            tick();
        end
        chk("div_cnt10", 32'(stall_cnt_o), 32'd10);
        lu_done_i = 1; lu_rd_i = 7; #1;
        chk("div_bypass", 32'(stallD_o), 32'd0);
        tick();
        chk("div_clr_pending", pending_o, 32'h0);
        chk("div_clr_outst", 32'(outst_o), 32'd0);
        chk("div_cnt_hold", 32'(stall_cnt_o), 32'd10);

        // 4: capacity limit and issue+done in the same cycle
        for (int i = 0; i < 4; i++) issue_long(5'(10 + i));
        chk("full_outst", 32'(outst_o), 32'd4);
        chk("full_pending", pending_o, 32'h0000_3C00);
        clear_inputs();
        longD_i = 1; rdD_addr_i = 20; rdD_wr_ena_i = 1; #1;
        chk("full_stall", 32'(stallD_o), 32'd1);
        longE_i = 1; rdE_wr_ena_i = 1; rdE_addr_i = 14; lu_done_i = 1; lu_rd_i = 10; #1;
        chk("full_release", 32'(stallD_o), 32'd0);
        tick();
        chk("issdone_outst", 32'(outst_o), 32'd4);
        chk("issdone_pending", pending_o, 32'h0000_7800);
        complete(11); complete(12); complete(13);
        chk("drain_outst", 32'(outst_o), 32'd1);
        clear_inputs();
        longE_i = 1; rdE_wr_ena_i = 1; rdE_addr_i = 14; lu_done_i = 1; lu_rd_i = 14;
        tick();
        chk("setclr_pending", pending_o, 32'h0000_4000);
        chk("setclr_outst", 32'(outst_o), 32'd1);
        complete(14);
        chk("drained", 32'(outst_o), 32'd0);

        // 5: WAW stall, then completion with nothing in flight
        issue_long(9);
        clear_inputs();
        rdD_addr_i = 9; rdD_wr_ena_i = 1; #1;
        chk("waw_stall", 32'(stallD_o), 32'd1);
        chk("waw_flushE", 32'(flushE_o), 32'd1);
        complete(9);
        chk("waw_done_outst", 32'(outst_o), 32'd0);
        chk("pre_proto_err", 32'(proto_err_o), 32'd0);
        complete(5);
        chk("proto_err_set", 32'(proto_err_o), 32'd1);
        chk("proto_outst", 32'(outst_o), 32'd0);
        clear_inputs();
        tick();
        chk("proto_sticky", 32'(proto_err_o), 32'd1);
        issue_long(0);
        chk("x0_never_pending", pending_o, 32'h0);
        complete(0);

        // 6: reset with three ops in flight
        issue_long(1); issue_long(2); issue_long(3);
        chk("pre_rst_outst", 32'(outst_o), 32'd3);
        clear_inputs();
        rs1D_addr_i = 1; rs1D_used_i = 1;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        clear_inputs(); #1;
        chk("mid_rst_pending", pending_o, 32'h0);
        chk("mid_rst_outst", 32'(outst_o), 32'd0);
        chk("mid_rst_cnt", 32'(stall_cnt_o), 32'd0);
        chk("mid_rst_proto", 32'(proto_err_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
